wash_cycle_sequencer: RTL and testbench

Consumer side of the preset store. Takes one preset (wash, rinse, spin, cloth, 5 bits each) as read out of the preset register bank, latches it on start, and runs the machine through fill, wash, rinse and spin phases. Each phase lasts its programmed number of time units, and the block drives the actuator enables. It sits between the preset mux outputs and the motor/valve/pump drivers.

---
 rtl/wash_cycle_sequencer_if.sv | 30 +++
 rtl/wash_cycle_sequencer.sv | 161 ++++++++++++++++
 tb/tb_wash_cycle_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/wash_cycle_sequencer_if.sv
// Preset/control inputs and phase/actuator outputs of the wash cycle sequencer.
// The master side presents a preset and requests; the slave side runs the cycle.
interface wash_cycle_sequencer_if;
   logic       start;
   logic       abort;
   logic [4:0] wash;
   logic [4:0] rinse;
   logic [4:0] spin;
   logic [4:0] cloth;
   logic [2:0] phase;
   logic [4:0] remaining;
   logic       busy;
   logic       done;
   logic       fill_valve;
   logic       motor_low;
   logic       motor_high;
   logic       drain_pump;

   modport master (
      output start, abort, wash, rinse, spin, cloth,
      input  phase, remaining, busy, done,
      input  fill_valve, motor_low, motor_high, drain_pump
   );

   modport slave (
      input  start, abort, wash, rinse, spin, cloth,
      output phase, remaining, busy, done,
      output fill_valve, motor_low, motor_high, drain_pump
   );
endinterface

// File: rtl/wash_cycle_sequencer.sv
// Latches a preset on start and steps FILL/WASH/RINSE/SPIN for the programmed
// number of time units each, skipping zero-length phases, then pulses DONE.
module wash_cycle_sequencer #(
   parameter int TICK_DIV = 1000,
   parameter int CNT_W    = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   wash_cycle_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FILL  = 3'd1,
      S_WASH  = 3'd2,
      S_RINSE = 3'd3,
      S_SPIN  = 3'd4,
      S_DONE  = 3'd5
   } phase_t;

   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

   phase_t           state_q,     state_d;
   logic [4:0]       remaining_q, remaining_d;
   logic [CNT_W-1:0] presc_q,     presc_d;
   logic [4:0]       wash_q,      wash_d;
   logic [4:0]       rinse_q,     rinse_d;
   logic [4:0]       spin_q,      spin_d;
   logic [4:0]       cloth_q,     cloth_d;

   logic             tick;
   phase_t           nxt_phase;

   // First phase strictly after cur (in FILL, WASH, RINSE, SPIN order) with a
   // nonzero duration; DONE when nothing is left.
   function automatic phase_t next_phase(input phase_t cur, input logic [4:0] c,
                                         input logic [4:0] w, input logic [4:0] r,
                                         input logic [4:0] s);
      phase_t nxt;
      logic   after_idle;
      logic   after_fill;
      logic   after_wash;
      logic   after_rinse;
      after_idle  = (cur == S_IDLE);
      after_fill  = after_idle | (cur == S_FILL);
      after_wash  = after_fill | (cur == S_WASH);
      after_rinse = after_wash | (cur == S_RINSE);
      nxt = S_DONE;
      if (after_idle && c != 5'd0) begin
         nxt = S_FILL;
      end else if (after_fill && w != 5'd0) begin
         nxt = S_WASH;
      end else if (after_wash && r != 5'd0) begin
         nxt = S_RINSE;
      end else if (after_rinse && s != 5'd0) begin
         nxt = S_SPIN;
      end
      return nxt;
   endfunction

   function automatic logic [4:0] duration_of(input phase_t ph, input logic [4:0] c,
                                              input logic [4:0] w, input logic [4:0] r,
                                              input logic [4:0] s);
      logic [4:0] d;
      d = 5'd0;
      case (ph)
         S_FILL:  d = c;
         S_WASH:  d = w;
         S_RINSE: d = r;
         S_SPIN:  d = s;
         default: d = 5'd0;
      endcase
      return d;
   endfunction

   assign tick = (presc_q == TICK_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         remaining_q <= 5'd0;
         presc_q     <= '0;
         wash_q      <= 5'd0;
         rinse_q     <= 5'd0;
         spin_q      <= 5'd0;
         cloth_q     <= 5'd0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         presc_q     <= presc_d;
         wash_q      <= wash_d;
         rinse_q     <= rinse_d;
         spin_q      <= spin_d;
         cloth_q     <= cloth_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      presc_d     = presc_q;
      wash_d      = wash_q;
      rinse_d     = rinse_q;
      spin_d      = spin_q;
      cloth_d     = cloth_q;
      nxt_phase   = S_DONE;

      case (state_q)
         S_IDLE: begin
            if (bus.start && !bus.abort) begin
               // Decide the first phase from the live inputs, since the latch
               // only becomes visible after this edge.
               wash_d      = bus.wash;
               rinse_d     = bus.rinse;
               spin_d      = bus.spin;
               cloth_d     = bus.cloth;
               nxt_phase   = next_phase(S_IDLE, bus.cloth, bus.wash, bus.rinse, bus.spin);
               state_d     = nxt_phase;
               remaining_d = duration_of(nxt_phase, bus.cloth, bus.wash, bus.rinse, bus.spin);
               presc_d     = '0;
            end
         end

         S_FILL, S_WASH, S_RINSE, S_SPIN: begin
            if (bus.abort) begin
               state_d     = S_IDLE;
               remaining_d = 5'd0;
               presc_d     = '0;
            end else if (tick) begin
               presc_d = '0;
               if (remaining_q == 5'd1) begin
                  nxt_phase   = next_phase(state_q, cloth_q, wash_q, rinse_q, spin_q);
                  state_d     = nxt_phase;
                  remaining_d = duration_of(nxt_phase, cloth_q, wash_q, rinse_q, spin_q);
               end else begin
                  remaining_d = remaining_q - 5'd1;
               end
            end else begin
               presc_d = presc_q + CNT_W'(1);
            end
         end

         default: begin
            state_d     = S_IDLE;
            remaining_d = 5'd0;
            presc_d     = '0;
         end
      endcase
   end

   assign bus.phase      = state_q;
   assign bus.remaining  = remaining_q;
   assign bus.busy       = (state_q == S_FILL) || (state_q == S_WASH) ||
                           (state_q == S_RINSE) || (state_q == S_SPIN);
   assign bus.done       = (state_q == S_DONE);
   assign bus.fill_valve = (state_q == S_FILL);
   assign bus.motor_low  = (state_q == S_WASH) || (state_q == S_RINSE);
   assign bus.motor_high = (state_q == S_SPIN);
   assign bus.drain_pump = (state_q == S_RINSE) || (state_q == S_SPIN);

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// Directed per-cycle vectors for the wash cycle sequencer at TICK_DIV=4, plus
// an asynchronous reset applied in the middle of SPIN.
module tb_wash_cycle_sequencer;

   localparam int TD = 4;

   typedef struct {
      logic       start;
      logic       abort;
      logic [4:0] cloth;
      logic [4:0] wash;
      logic [4:0] rinse;
      logic [4:0] spin;
      logic [2:0] exp_phase;
      logic [4:0] exp_rem;
   } vec_t;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_miss;
   vec_t vecs[$];

   wash_cycle_sequencer_if bus_if();

   wash_cycle_sequencer #(.TICK_DIV(TD), .CNT_W(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {phase, remaining, busy, done, fill_valve, motor_low, motor_high, drain_pump}
   function automatic logic [13:0] expect_word(input logic [2:0] ph, input logic [4:0] rem);
      logic b, d, fv, ml, mh, dp;
      b  = (ph >= 3'd1) && (ph <= 3'd4);
      d  = (ph == 3'd5);
      fv = (ph == 3'd1);
      ml = (ph == 3'd2) || (ph == 3'd3);
      mh = (ph == 3'd4);
      dp = (ph == 3'd3) || (ph == 3'd4);
      return {ph, rem, b, d, fv, ml, mh, dp};
   endfunction

   function automatic logic [13:0] actual_word();
      return {bus_if.phase, bus_if.remaining, bus_if.busy, bus_if.done,
              bus_if.fill_valve, bus_if.motor_low, bus_if.motor_high, bus_if.drain_pump};
   endfunction

   task automatic check(input string name, input logic [13:0] exp_w);
      logic [13:0] act_w;
      act_w = actual_word();
      n_vec++;
      if (act_w !== exp_w) begin
         n_miss++;
         $display("FAIL %s: got phase=%0d rem=%0d flags=%b, want phase=%0d rem=%0d flags=%b",
                  name, act_w[13:11], act_w[10:6], act_w[5:0],
                  exp_w[13:11], exp_w[10:6], exp_w[5:0]);
      end else begin
         $display("ok   %s: phase=%0d rem=%0d flags=%b", name, act_w[13:11], act_w[10:6], act_w[5:0]);
      end
   endtask

   task automatic add_vec(input logic st, input logic ab, input logic [4:0] c,
                          input logic [4:0] w, input logic [4:0] r, input logic [4:0] s,
                          input logic [2:0] ph, input logic [4:0] rem);
      vec_t v;
      v.start = st; v.abort = ab;
      v.cloth = c; v.wash = w; v.rinse = r; v.spin = s;
      v.exp_phase = ph; v.exp_rem = rem;
      vecs.push_back(v);
   endtask

   // A whole phase of `units` time units; non-start cycles present junk presets.
   task automatic add_run(input logic [2:0] ph, input int units, input int start_k,
                          input logic [4:0] c, input logic [4:0] w,
                          input logic [4:0] r, input logic [4:0] s);
      for (int k = 0; k < units * TD; k++) begin
         if (k == start_k)
            add_vec(1'b1, 1'b0, c, w, r, s, ph, 5'(units - k / TD));
         else
            add_vec(1'b0, 1'b0, 5'd9, 5'd9, 5'd9, 5'd9, ph, 5'(units - k / TD));
      end
   endtask

   task automatic drive(input logic st, input logic ab, input logic [4:0] c,
                        input logic [4:0] w, input logic [4:0] r, input logic [4:0] s);
      bus_if.start = st; bus_if.abort = ab;
      bus_if.cloth = c;  bus_if.wash = w; bus_if.rinse = r; bus_if.spin = s;
   endtask

   initial begin
      n_vec  = 0;
      n_miss = 0;
      rst    = 1'b1;
      drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);

      // Full cycle: FILL 2, WASH 3, RINSE 1 (start re-pulsed, ignored), SPIN 2
      add_vec(0, 0, 0, 0, 0, 0, 3'd0, 5'd0);
      add_run(3'd1, 2, 0,  5'd2, 5'd3, 5'd1, 5'd2);
      add_run(3'd2, 3, -1, 5'd9, 5'd9, 5'd9, 5'd9);
      add_run(3'd3, 1, 1,  5'd31, 5'd31, 5'd31, 5'd31);
      add_run(3'd4, 2, -1, 5'd9, 5'd9, 5'd9, 5'd9);
      add_vec(0, 0, 9, 9, 9, 9, 3'd5, 5'd0);
      // start in DONE ignored; start on the following IDLE cycle accepted (zero skip)
      add_vec(1, 0, 1, 1, 1, 1, 3'd0, 5'd0);
      add_run(3'd2, 2, 0, 5'd0, 5'd2, 5'd0, 5'd0);
      add_vec(0, 0, 9, 9, 9, 9, 3'd5, 5'd0);
      add_vec(0, 0, 9, 9, 9, 9, 3'd0, 5'd0);
      // All-zero preset goes straight to DONE
      add_vec(1, 0, 0, 0, 0, 0, 3'd5, 5'd0);
      add_vec(0, 0, 9, 9, 9, 9, 3'd0, 5'd0);
      // start together with abort in IDLE is ignored
      add_vec(1, 1, 1, 1, 1, 1, 3'd0, 5'd0);
      add_vec(0, 0, 9, 9, 9, 9, 3'd0, 5'd0);
      // Abort on the final WASH tick: straight to IDLE, no done
      add_vec(1, 0, 0, 1, 0, 1, 3'd2, 5'd1);
      add_vec(0, 0, 9, 9, 9, 9, 3'd2, 5'd1);
      add_vec(0, 0, 9, 9, 9, 9, 3'd2, 5'd1);
      add_vec(0, 0, 9, 9, 9, 9, 3'd2, 5'd1);
      add_vec(0, 1, 9, 9, 9, 9, 3'd0, 5'd0);
      add_vec(0, 0, 9, 9, 9, 9, 3'd0, 5'd0);
      add_vec(0, 0, 9, 9, 9, 9, 3'd0, 5'd0);

      #1;
      check("reset_async", expect_word(3'd0, 5'd0));
      @(posedge clk);
      @(posedge clk);
      #1;
      check("reset_held", expect_word(3'd0, 5'd0));
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i].start, vecs[i].abort, vecs[i].cloth,
               vecs[i].wash, vecs[i].rinse, vecs[i].spin);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d", i), expect_word(vecs[i].exp_phase, vecs[i].exp_rem));
      end

      // Asynchronous reset asserted mid-SPIN, between clock edges
      drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 5'd2);
      @(posedge clk);
      #1;
      check("spin_entry", expect_word(3'd4, 5'd2));
      drive(1'b0, 1'b0, 5'd9, 5'd9, 5'd9, 5'd9);
      @(posedge clk);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("reset_mid_spin", expect_word(3'd0, 5'd0));
      @(posedge clk);
      #1;
      check("reset_mid_spin_held", expect_word(3'd0, 5'd0));
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("idle_after_reset", expect_word(3'd0, 5'd0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
